// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : frame-level types and constants shared by the 8N1 UART blocks
// Revision : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_sync2 : two-flop synchronizer with programmable reset value
// Revision   : 1.0
// ----------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= RESET_VAL;
      r_s2 <= RESET_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx  : 8N1 UART receiver with oversampled mid-bit sampling, false-start
//            rejection, frame-error and sticky overrun reporting
// Revision : 1.0
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 rx_in,
  input  logic                 read_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] c_START_TGT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] c_BIT_TGT   = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] c_LAST_IDX  = IW'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_tick_hit;
  state_t               r_state;
  logic [TW-1:0]        r_tick;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_disarm;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_ready;
  logic                 r_ferr;
  logic                 r_ovr;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx_in),
    .o_q   (w_rx_s)
  );

  // START samples half a bit in; DATA and STOP sample one full bit apart.
  assign w_tick_hit = (r_tick == ((r_state == START) ? c_START_TGT : c_BIT_TGT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_tick   <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_disarm <= 1'b0;
      r_data   <= '0;
      r_ready  <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (read_en) begin
        r_ready <= 1'b0;
        r_ferr  <= 1'b0;
        r_ovr   <= 1'b0;
      end
      if (rx_en) begin
        unique case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state <= START;
              r_tick  <= '0;
            end
          end
          START: begin
            if (w_tick_hit) begin
              if (w_rx_s) begin
                r_state <= IDLE;
              end else begin
                r_state <= DATA;
                r_tick  <= '0;
                r_idx   <= '0;
              end
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          DATA: begin
            if (w_tick_hit) begin
              r_shift[r_idx] <= w_rx_s;
              r_tick         <= '0;
              if (r_idx == c_LAST_IDX) r_state <= STOP;
              else                     r_idx   <= r_idx + IW'(1);
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          STOP: begin
            // A low stop bit parks here until the line recovers, so a break yields one frame.
            if (r_disarm) begin
              if (w_rx_s) begin
                r_state  <= IDLE;
                r_disarm <= 1'b0;
              end
            end else if (w_tick_hit) begin
              r_data  <= r_shift;
              r_ready <= 1'b1;
              r_ferr  <= ~w_rx_s;
              r_ovr   <= (r_ovr | r_ready) & ~read_en;
              if (w_rx_s) r_state  <= IDLE;
              else        r_disarm <= 1'b1;
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_ready  = r_ready;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
